// File: rtl/fuzzy_sample_sequencer_pkg.sv
// Shared constants for the fuzzy sample sequencer: core MMIO map,
// CTRL bit positions, sequencer state enum and CTRL word builder.
package fuzzy_sample_sequencer_pkg;

    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h01;
    localparam logic [7:0] ADDR_T      = 8'h02;
    localparam logic [7:0] ADDR_DT     = 8'h03;
    localparam logic [7:0] ADDR_GOUT   = 8'h04;

    localparam int CTRL_START    = 0;
    localparam int CTRL_REG_MODE = 1;
    localparam int CTRL_DT_MODE  = 2;
    localparam int CTRL_INIT     = 3;

    typedef enum logic [2:0] {
        S_WAIT_TICK,
        S_GET_SAMPLE,
        S_WR_T,
        S_WR_DT,
        S_WR_CTRL,
        S_WAIT_VALID,
        S_RD_G,
        S_PUSH
    } seq_state_e;

    function automatic logic [7:0] ctrl_word(input logic dt_mode,
                                             input logic reg_mode);
        logic [7:0] w;
        w                = '0;
        w[CTRL_START]    = 1'b1;
        w[CTRL_REG_MODE] = reg_mode;
        w[CTRL_DT_MODE]  = dt_mode;
        w[CTRL_INIT]     = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/fuzzy_sample_sequencer_if.sv
// Bus bundle of the sequencer: sample input handshake, result output
// handshake and the MMIO master port plus status pins of the fuzzy core.
// master = sequencer side, slave = sensor/consumer/core side.
interface fuzzy_sample_sequencer_if;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] sample_t;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_g;
    logic       res_err;
    logic       m_cs;
    logic       m_rd;
    logic       m_wr;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    logic       core_busy;
    logic       core_valid;

    modport master (
        input  sample_valid, sample_t, res_ready,
        input  m_rdata, core_busy, core_valid,
        output sample_ready, res_valid, res_g, res_err,
        output m_cs, m_rd, m_wr, m_addr, m_wdata
    );

    modport slave (
        output sample_valid, sample_t, res_ready,
        output m_rdata, core_busy, core_valid,
        input  sample_ready, res_valid, res_g, res_err,
        input  m_cs, m_rd, m_wr, m_addr, m_wdata
    );
endinterface

// File: rtl/fuzzy_sample_sequencer_sat_sub8.sv
// sat_sub8: combinational signed 8-bit a - b, clamped to [-128,+127].
// Ports: a, b (signed 8) in; y (signed 8) out.
module sat_sub8 (
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    output logic signed [7:0] y
);
    logic [8:0] diff;

    always_comb begin
        diff = {a[7], a} - {b[7], b};
        y    = diff[7:0];
        // 9-bit result not representable in 8 bits: clamp by sign
        if (diff[8] != diff[7]) begin
            y = diff[8] ? 8'sh80 : 8'sh7F;
        end
    end
endmodule

// File: rtl/fuzzy_sample_sequencer.sv
// Autonomous MMIO master sequencing the fuzzy core once per period tick.
// Ports: clk, rst_n, enable, cfg_period/reg_mode/dt_mode, overrun, bus.
module fuzzy_sample_sequencer
    import fuzzy_sample_sequencer_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_reg_mode,
    input  logic                cfg_dt_mode,
    output logic                overrun,
    fuzzy_sample_sequencer_if.master bus
);
    localparam int WC_W = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    seq_state_e          state_q, state_d;
    logic                gap_q, gap_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [WC_W-1:0]     wcnt_q, wcnt_d;
    logic [7:0]          t_q, t_d, t_prev_q, t_prev_d;
    logic                first_q, first_d;
    logic                dtm_q, dtm_d, rm_q, rm_d;
    logic [7:0]          res_g_q, res_g_d;
    logic                res_err_q, res_err_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic [7:0]          dt_raw, dt_val;
    logic                sample_ready, res_valid;
    logic                m_cs, m_rd, m_wr;
    logic [7:0]          m_addr, m_wdata;
    logic                unused_busy;

    // completion is taken from the valid pulse only
    assign unused_busy = bus.core_busy;

    // >= so a shrinking cfg_period never strands the counter
    assign tick   = enable && (cnt_q >= cfg_period);
    assign dt_val = first_q ? 8'h00 : dt_raw;

    sat_sub8 u_sat (
        .a (t_q),
        .b (t_prev_q),
        .y (dt_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT_TICK;
            gap_q     <= 1'b0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            t_q       <= '0;
            t_prev_q  <= '0;
            first_q   <= 1'b1;
            dtm_q     <= 1'b0;
            rm_q      <= 1'b0;
            res_g_q   <= '0;
            res_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            t_q       <= t_d;
            t_prev_q  <= t_prev_d;
            first_q   <= first_d;
            dtm_q     <= dtm_d;
            rm_q      <= rm_d;
            res_g_q   <= res_g_d;
            res_err_q <= res_err_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        t_d          = t_q;
        t_prev_d     = t_prev_q;
        first_d      = first_q;
        dtm_d        = dtm_q;
        rm_d         = rm_q;
        res_g_d      = res_g_q;
        res_err_d    = res_err_q;
        overrun_d    = overrun_q;
        sample_ready = 1'b0;
        res_valid    = 1'b0;
        m_cs         = 1'b0;
        m_rd         = 1'b0;
        m_wr         = 1'b0;
        m_addr       = ADDR_STATUS;
        m_wdata      = 8'h00;

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PERIOD_W'(1);
        end
        if (tick && (state_q != S_WAIT_TICK)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_WAIT_TICK: begin
                if (tick) state_d = S_GET_SAMPLE;
            end
            S_GET_SAMPLE: begin
                sample_ready = 1'b1;
                if (bus.sample_valid) begin
                    t_d     = bus.sample_t;
                    dtm_d   = cfg_dt_mode;
                    rm_d    = cfg_reg_mode;
                    gap_d   = 1'b0;
                    state_d = S_WR_T;
                end
            end
            S_WR_T: begin
                gap_d = ~gap_q;
                if (!gap_q) begin
                    m_cs    = 1'b1;
                    m_wr    = 1'b1;
                    m_addr  = ADDR_T;
                    m_wdata = t_q;
                end else begin
                    state_d = dtm_q ? S_WR_CTRL : S_WR_DT;
                end
            end
            S_WR_DT: begin
                gap_d = ~gap_q;
                if (!gap_q) begin
                    m_cs    = 1'b1;
                    m_wr    = 1'b1;
                    m_addr  = ADDR_DT;
                    m_wdata = dt_val;
                end else begin
                    t_prev_d = t_q;
                    first_d  = 1'b0;
                    state_d  = S_WR_CTRL;
                end
            end
            S_WR_CTRL: begin
                gap_d = ~gap_q;
                if (!gap_q) begin
                    m_cs    = 1'b1;
                    m_wr    = 1'b1;
                    m_addr  = ADDR_CTRL;
                    m_wdata = ctrl_word(dtm_q, rm_q);
                end else begin
                    wcnt_d  = '0;
                    state_d = S_WAIT_VALID;
                end
            end
            S_WAIT_VALID: begin
                if (bus.core_valid) begin
                    gap_d   = 1'b0;
                    state_d = S_RD_G;
                end else if (wcnt_q == WC_LAST) begin
                    res_err_d = 1'b1;
                    res_g_d   = 8'h00;
                    first_d   = 1'b1;
                    state_d   = S_PUSH;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            S_RD_G: begin
                gap_d = ~gap_q;
                if (!gap_q) begin
                    m_cs   = 1'b1;
                    m_rd   = 1'b1;
                    m_addr = ADDR_GOUT;
                end else begin
                    res_g_d   = bus.m_rdata;
                    res_err_d = 1'b0;
                    state_d   = S_PUSH;
                end
            end
            S_PUSH: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_d = S_WAIT_TICK;
            end
            default: state_d = S_WAIT_TICK;
        endcase

        // dT history is meaningless across a disabled stretch
        if (!enable) first_d = 1'b1;
    end

    assign bus.sample_ready = sample_ready;
    assign bus.res_valid    = res_valid;
    assign bus.res_g        = res_g_q;
    assign bus.res_err      = res_err_q;
    assign bus.m_cs         = m_cs;
    assign bus.m_rd         = m_rd;
    assign bus.m_wr         = m_wr;
    assign bus.m_addr       = m_addr;
    assign bus.m_wdata      = m_wdata;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_fuzzy_sample_sequencer.sv
// Self-checking bench for fuzzy_sample_sequencer with a behavioural
// core stub on the MMIO port and a conversion-level reference model.
module tb_fuzzy_sample_sequencer;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable;
    logic [15:0] cfg_period;
    logic        cfg_reg_mode;
    logic        cfg_dt_mode;
    logic        overrun;

    fuzzy_sample_sequencer_if bus();

    fuzzy_sample_sequencer #(.PERIOD_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_period   (cfg_period),
        .cfg_reg_mode (cfg_reg_mode),
        .cfg_dt_mode  (cfg_dt_mode),
        .overrun      (overrun),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ctrl_cyc = 0;
    int proto_err = 0;
    int vcnt = 0;
    int stub_lat = 1;
    bit stub_dead = 1'b0;
    bit prev_cs = 1'b0;
    logic [7:0]  st_t = 8'h00;
    logic [7:0]  st_dt = 8'h00;
    logic [16:0] trace[$];

    // reference model state
    bit         mdl_first = 1'b1;
    logic [7:0] mdl_prev = 8'h00;
    logic [7:0] mdl_last_dt = 8'h00;

    function automatic logic [7:0] g_fn(input logic [7:0] t, input logic [7:0] d);
        return t ^ (d + 8'h35);
    endfunction

    function automatic logic [7:0] sat_diff(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        if (d > 127) d = 127;
        else if (d < -128) d = -128;
        return d[7:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.core_busy = (vcnt != 0);

    // core stub: register file, one-cycle valid pulse, registered read data
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt           <= 0;
            bus.core_valid <= 1'b0;
            bus.m_rdata    <= 8'h00;
            prev_cs        <= 1'b0;
            st_t           <= 8'h00;
            st_dt          <= 8'h00;
        end else begin
            bus.core_valid <= 1'b0;
            prev_cs        <= bus.m_cs;
            if (vcnt != 0) begin
                vcnt <= vcnt - 1;
                if (vcnt == 1) bus.core_valid <= 1'b1;
            end
            if (!bus.m_cs && (bus.m_rd || bus.m_wr)) proto_err <= proto_err + 1;
            if (bus.m_cs) begin
                trace.push_back({bus.m_rd, bus.m_addr, bus.m_rd ? 8'h00 : bus.m_wdata});
                if (prev_cs || (bus.m_rd == bus.m_wr)) proto_err <= proto_err + 1;
                if (bus.m_wr && bus.m_addr == 8'h02) st_t <= bus.m_wdata;
                if (bus.m_wr && bus.m_addr == 8'h03) st_dt <= bus.m_wdata;
                if (bus.m_wr && bus.m_addr == 8'h01 && bus.m_wdata[0]) begin
                    ctrl_cyc <= cyc;
                    if (!stub_dead) vcnt <= stub_lat;
                end
                if (bus.m_rd && bus.m_addr == 8'h04) bus.m_rdata <= g_fn(st_t, st_dt);
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mdl_first = 1'b1;
        mdl_prev = 8'h00;
        mdl_last_dt = 8'h00;
    endtask

    task automatic do_conv(input logic [7:0] t, input bit dtm, input bit rm,
                           input bit dead, input int rdy_dly,
                           output logic [7:0] dt_seen, output logic [7:0] ctrl_seen);
        logic [16:0] exp_q[$];
        logic [16:0] e;
        logic [7:0]  dt_exp, g_exp;
        int base, n, nt;
        bit ok;
        dt_seen = 8'h00;
        ctrl_seen = 8'h00;
        base = trace.size();
        dt_exp = mdl_first ? 8'h00 : sat_diff(t, mdl_prev);
        exp_q.push_back({1'b0, 8'h02, t});
        if (!dtm) exp_q.push_back({1'b0, 8'h03, dt_exp});
        exp_q.push_back({1'b0, 8'h01, {5'b0, dtm, rm, 1'b1}});
        if (!dead) exp_q.push_back({1'b1, 8'h04, 8'h00});
        if (!dtm) mdl_last_dt = dt_exp;
        g_exp = dead ? 8'h00 : g_fn(t, mdl_last_dt);
        cfg_dt_mode = dtm;
        cfg_reg_mode = rm;
        stub_dead = dead;
        stub_lat = $urandom_range(1, 6);
        bus.sample_t = t;
        bus.sample_valid = 1'b1;
        n = 0;
        while (!bus.sample_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 400) begin
            $display("FAIL sample_ready_wait: not seen in %0d cycles, required 1", n);
            miscompares++;
            bus.sample_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            $display("FAIL res_valid_wait: not seen in %0d cycles, required 1", n);
            miscompares++;
            return;
        end
        nt = trace.size() - base;
        ok = (nt == exp_q.size());
        for (int i = 0; i < nt; i++) begin
            e = trace[base + i];
            if (e[16] == 1'b0 && e[15:8] == 8'h03) dt_seen = e[7:0];
            if (e[16] == 1'b0 && e[15:8] == 8'h01) ctrl_seen = e[7:0];
            if (ok && e !== exp_q[i]) begin
                ok = 1'b0;
                $display("FAIL mmio_trace[%0d]: got %h required %h", i, e, exp_q[i]);
            end
        end
        vectors++;
        if (!ok) begin
            if (nt != exp_q.size())
                $display("FAIL mmio_trace_len: got %0d required %0d", nt, exp_q.size());
            miscompares++;
        end
        vectors++;
        if (bus.res_err !== dead) begin
            $display("FAIL res_err: got %b required %b", bus.res_err, dead);
            miscompares++;
        end
        vectors++;
        if (bus.res_g !== g_exp) begin
            $display("FAIL res_g: got %h required %h", bus.res_g, g_exp);
            miscompares++;
        end
        if (dead) begin
            vectors++;
            if (cyc - ctrl_cyc != TIMEOUT + 2) begin
                $display("FAIL timeout_latency: got %0d required %0d", cyc - ctrl_cyc, TIMEOUT + 2);
                miscompares++;
            end
        end
        vectors++;
        if (proto_err != 0) begin
            $display("FAIL mmio_protocol: got %0d errors required 0", proto_err);
            miscompares++;
        end
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.res_valid, bus.res_err, bus.res_g, bus.sample_ready} !==
                {1'b1, dead, g_exp, 1'b0}) begin
                $display("FAIL hold_stable: got v=%b e=%b g=%h sr=%b required v=1 e=%b g=%h sr=0",
                         bus.res_valid, bus.res_err, bus.res_g, bus.sample_ready, dead, g_exp);
                miscompares++;
            end
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        vectors++;
        if (bus.res_valid !== 1'b0) begin
            $display("FAIL res_release: res_valid got %b required 0", bus.res_valid);
            miscompares++;
        end
        if (!dtm) begin
            mdl_prev = t;
            mdl_first = 1'b0;
        end
        if (dead) mdl_first = 1'b1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({bus.sample_ready, bus.res_valid, bus.res_g, bus.res_err, overrun,
             bus.m_cs, bus.m_rd, bus.m_wr, bus.m_addr, bus.m_wdata} !== '0) begin
            $display("FAIL reset_outputs: got nonzero outputs during reset");
            miscompares++;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.sample_ready, bus.res_valid, bus.m_cs} !== 3'b000) begin
            $display("FAIL post_reset_idle: got %b required 000",
                     {bus.sample_ready, bus.res_valid, bus.m_cs});
            miscompares++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] d, c;
        apply_reset();
        cfg_period = 16'd10;
        do_conv(8'h00, 1'b0, 1'b1, 1'b0, 0, d, c);
        vectors++;
        if ({d, c} !== {8'h00, 8'h03}) begin
            $display("FAIL basic_first: dt/ctrl got %h/%h required 00/03", d, c);
            miscompares++;
        end
        do_conv(8'h20, 1'b0, 1'b1, 1'b0, 1, d, c);
        vectors++;
        if ({d, c} !== {8'h20, 8'h03}) begin
            $display("FAIL basic_second: dt/ctrl got %h/%h required 20/03", d, c);
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        logic [7:0] d, c;
        cfg_period = 16'd40;
        do_conv(8'h9C, 1'b0, 1'b0, 1'b0, 0, d, c);
        do_conv(8'h64, 1'b0, 1'b0, 1'b0, 0, d, c);
        vectors++;
        if (d !== 8'h7F) begin
            $display("FAIL sat_pos: dt got %h required 7f", d);
            miscompares++;
        end
        do_conv(8'h9C, 1'b0, 1'b0, 1'b0, 0, d, c);
        vectors++;
        if (d !== 8'h80) begin
            $display("FAIL sat_neg: dt got %h required 80", d);
            miscompares++;
        end
    endtask

    task automatic test_dt_mode();
        logic [7:0] d, c;
        do_conv(8'h11, 1'b1, 1'b0, 1'b0, 0, d, c);
        vectors++;
        if (c !== 8'h05) begin
            $display("FAIL dtmode_ctrl: got %h required 05", c);
            miscompares++;
        end
        do_conv(8'hF0, 1'b1, 1'b1, 1'b0, 2, d, c);
        vectors++;
        if (c !== 8'h07) begin
            $display("FAIL dtmode_ctrl2: got %h required 07", c);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d, c;
        do_conv(8'h32, 1'b0, 1'b1, 1'b0, 0, d, c);
        do_conv(8'h5A, 1'b0, 1'b1, 1'b1, 0, d, c);
        do_conv(8'h14, 1'b0, 1'b1, 1'b0, 0, d, c);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL timeout_dt_restart: dt got %h required 00", d);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d, c;
        apply_reset();
        cfg_period = 16'd40;
        do_conv(8'h21, 1'b0, 1'b0, 1'b0, 0, d, c);
        vectors++;
        if (overrun !== 1'b0) begin
            $display("FAIL overrun_clear: got %b required 0", overrun);
            miscompares++;
        end
        cfg_period = 16'd4;
        do_conv(8'h40, 1'b0, 1'b0, 1'b0, 30, d, c);
        vectors++;
        if (overrun !== 1'b1) begin
            $display("FAIL overrun_set: got %b required 1", overrun);
            miscompares++;
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d, c;
        int n;
        cfg_period = 16'd40;
        do_conv(8'h70, 1'b0, 1'b0, 1'b0, 0, d, c);
        stub_dead = 1'b1;
        bus.sample_t = 8'h10;
        bus.sample_valid = 1'b1;
        n = 0;
        while (!bus.sample_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.sample_ready, bus.res_valid, bus.res_g, bus.res_err, overrun,
             bus.m_cs, bus.m_rd, bus.m_wr, bus.m_addr, bus.m_wdata} !== '0) begin
            $display("FAIL midreset_outputs: got nonzero outputs on reset assertion");
            miscompares++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stub_dead = 1'b0;
        mdl_first = 1'b1;
        mdl_prev = 8'h00;
        mdl_last_dt = 8'h00;
        do_conv(8'h30, 1'b0, 1'b1, 1'b0, 0, d, c);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL midreset_dt: got %h required 00", d);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [7:0] d, c;
        for (int i = 0; i < 14; i++) begin
            cfg_period = 16'($urandom_range(20, 50));
            if ($urandom_range(0, 4) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                enable = 1'b1;
                mdl_first = 1'b1;
            end
            do_conv(8'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 4), d, c);
        end
    endtask

    initial begin
        enable = 1'b1;
        cfg_period = 16'd10;
        cfg_reg_mode = 1'b0;
        cfg_dt_mode = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_t = 8'h00;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_dt_mode();
        test_timeout();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
